kbd_scode_dec: RTL and testbench
================================

// Module: kbd_scode_dec
// PURPOSE
//  Consumes PS/2 set-2 scan-code bytes from the PS/2 receiver (scode/scode_en/rx_err) and decodes them into key events.
//  Prefixes handled: F0 (break), E0 (extended), E1 (pause). Tracks modifier state; buffers events in a FIFO behind
//  a valid/ready handshake for the host-side consumer (CPU bridge / key-event sink).
// PARAMETERS
//  P_FIFO_DEPTH     8            event FIFO entries; power of 2, >=2
//  P_PFX_TIMEOUT    32'd1000000  clk cycles allowed between bytes of a multi-byte sequence before abort
// PORTS
//  clk        in   1   system clock (single clock domain)
//  rst        in   1   synchronous, active-high reset
//  scode      in   8   received byte; valid only when scode_en=1
//  scode_en   in   1   1-cycle strobe per received byte
//  rx_err     in   8   receiver status; [0] parity, [1] stop, [2] timeout; sampled on scode_en
//  ev_code    out  8   event scan code (base byte, prefixes stripped)
//  ev_brk     out  1   1 = key release, 0 = press
//  ev_ext     out  1   1 = E0-prefixed key
//  ev_ascii   out  8   ASCII of event (see CONFIGURATION)
//  ev_valid   out  1   FIFO head valid
//  ev_ready   in   1   consumer accepts head when ev_valid&ev_ready
//  mods       out  4   live modifiers {alt, ctrl, rshift, lshift}
//  bat_ok     out  1   1-cycle pulse on standalone AA byte in IDLE
//  ovf        out  1   sticky: event dropped on full FIFO
//  ovf_clr    in   1   clears ovf (ovf_clr wins over same-cycle set)
//  err_cnt    out  8   saturating count of discarded bytes/sequences
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, all outputs 0 (ev_valid=0, mods=0, ovf=0, err_cnt=0, bat_ok=0).
//  Byte acceptance: on scode_en, if rx_err[2:0]!=0 -> discard byte, state->IDLE, err_cnt++.
//  FSM (advances only on accepted byte, except timeout):
//   IDLE:    F0->BRK; E0->EXT; E1->PAUSE(skip=7); AA->bat_ok pulse; 00/FF->err_cnt++; FA/FE/EE ignored;
//            else emit {code, brk=0, ext=0}
//   BRK:     emit {code, brk=1, ext=0} -> IDLE
//   EXT:     F0->EXT_BRK; 12 or 59 (fake shift) -> IDLE, no event; else emit {code,0,1} -> IDLE
//   EXT_BRK: 12/59 -> IDLE, no event; else emit {code,1,1} -> IDLE
//   PAUSE:   consume 7 bytes; after 7th emit {8'hE1,0,0} -> IDLE
//  Prefix timeout: counter clears on each accepted byte, runs in any state != IDLE;
//   at P_PFX_TIMEOUT-1 -> IDLE, err_cnt++, no event.
//  Any prefix byte (F0/E0/E1) in BRK/EXT_BRK: protocol error -> IDLE, err_cnt++.
//  mods: update on every emitted event regardless of FIFO space.
//   12=lshift, 59=rshift, 14=ctrl (ext or not), 11=alt (ext or not); set on make, clear on break.
//  Latency: final byte scode_en at cycle N -> event register N+1 -> FIFO write -> ev_valid=1 at N+2 if FIFO empty.
//  FIFO: no fall-through; head outputs registered; pop when ev_valid&ev_ready.
//   Full & push & no pop: event dropped, ovf=1.
//   Full & push & pop same cycle: both accepted.
//   Empty: pop ignored.
//  err_cnt saturates at 8'hFF. rst mid-sequence: state and FIFO cleared next edge, partial sequence lost.
// CONFIGURATION
//  KBD_DEC_ASCII_EN defined: ev_ascii from set-2 table for non-ext make codes.
//   Letters/digits/punctuation shifted when lshift|rshift; 0D enter, 08 backspace, 1B esc, 20 space;
//   unmapped, ext or break -> 8'h00. Stored in FIFO with event.
//  Not defined: ev_ascii tied 8'h00, no table logic, FIFO width excludes ascii.
// STRUCTURE
//  kbd_pkg: SC_BRK=8'hF0, SC_EXT=8'hE0, SC_PAUSE=8'hE1, SC_BAT=8'hAA, modifier codes,
//   FSM state enum, kbd_ev_t struct {code, brk, ext, ascii}.
//  Sub-module kbd_ev_fifo: generic sync FIFO (DEPTH, WIDTH), push/pop/full/empty, registered head.
//  ASCII table: function in kbd_pkg, guarded by KBD_DEC_ASCII_EN.
// TESTING
//  1C -> one event {1C,brk0,ext0}, ev_valid 2 cycles after strobe; ascii 61 ('a') when ASCII_EN.
//  12, 1C, F0 1C, F0 12 -> mods[0] 1 then 0; events {12,0,0},{1C,0,0} ascii 41,{1C,1,0},{12,1,0}.
//  E0 F0 75 -> {75,brk1,ext1}; E0 12 E0 7C -> single {7C,0,1}, no shift event.
//  E1 14 77 E1 F0 14 F0 77 -> single {E1,0,0}; err_cnt unchanged.
//  ev_ready=0, send 9 makes (DEPTH 8) -> 8 buffered, ovf=1; ovf_clr -> ovf 0; drain in order.
//  F0 then no byte for P_PFX_TIMEOUT cycles -> IDLE, err_cnt=1; next 1C -> {1C,0,0} make;
//   byte with rx_err=8'h01 -> discarded, err_cnt++.

Source files
------------

// File: rtl/kbd_scode_dec_pkg.sv
// Shared constants, FSM state, event record and the set-2 ASCII table for the scan-code decoder.
// Optional ASCII translation is enabled with KBD_DEC_ASCII_EN.
package kbd_scode_dec_pkg;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;

    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK,
        S_PAUSE
    } kbd_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [7:0] ascii;
    } kbd_ev_t;

`ifdef KBD_DEC_ASCII_EN
    localparam int EV_W = 18;

    // Returns {unshifted, shifted} pair selected by shift; unmapped codes give 8'h00.
    function automatic logic [7:0] kbd_ascii(input logic [7:0] code, input logic shift);
        logic [7:0] lo;
        logic [7:0] hi;
        {lo, hi} = 16'h0000;
        case (code)
            8'h1C: {lo, hi} = "aA";  8'h32: {lo, hi} = "bB";  8'h21: {lo, hi} = "cC";
            8'h23: {lo, hi} = "dD";  8'h24: {lo, hi} = "eE";  8'h2B: {lo, hi} = "fF";
            8'h34: {lo, hi} = "gG";  8'h33: {lo, hi} = "hH";  8'h43: {lo, hi} = "iI";
            8'h3B: {lo, hi} = "jJ";  8'h42: {lo, hi} = "kK";  8'h4B: {lo, hi} = "lL";
            8'h3A: {lo, hi} = "mM";  8'h31: {lo, hi} = "nN";  8'h44: {lo, hi} = "oO";
            8'h4D: {lo, hi} = "pP";  8'h15: {lo, hi} = "qQ";  8'h2D: {lo, hi} = "rR";
            8'h1B: {lo, hi} = "sS";  8'h2C: {lo, hi} = "tT";  8'h3C: {lo, hi} = "uU";
            8'h2A: {lo, hi} = "vV";  8'h1D: {lo, hi} = "wW";  8'h22: {lo, hi} = "xX";
            8'h35: {lo, hi} = "yY";  8'h1A: {lo, hi} = "zZ";
            8'h45: {lo, hi} = "0)";  8'h16: {lo, hi} = "1!";  8'h1E: {lo, hi} = "2@";
            8'h26: {lo, hi} = "3#";  8'h25: {lo, hi} = "4$";  8'h2E: {lo, hi} = "5%";
            8'h36: {lo, hi} = "6^";  8'h3D: {lo, hi} = "7&";  8'h3E: {lo, hi} = "8*";
            8'h46: {lo, hi} = "9(";
            8'h0E: {lo, hi} = {8'h60, 8'h7E};
            8'h4E: {lo, hi} = "-_";  8'h55: {lo, hi} = "=+";  8'h54: {lo, hi} = "[{";
            8'h5B: {lo, hi} = "]}";  8'h5D: {lo, hi} = {8'h5C, 8'h7C};
            8'h4C: {lo, hi} = ";:";  8'h52: {lo, hi} = {8'h27, 8'h22};
            8'h41: {lo, hi} = ",<";  8'h49: {lo, hi} = ".>";  8'h4A: {lo, hi} = "/?";
            8'h5A: {lo, hi} = {8'h0D, 8'h0D};
            8'h66: {lo, hi} = {8'h08, 8'h08};
            8'h76: {lo, hi} = {8'h1B, 8'h1B};
            8'h29: {lo, hi} = {8'h20, 8'h20};
            default: {lo, hi} = 16'h0000;
        endcase
        return shift ? hi : lo;
    endfunction
`else
    localparam int EV_W = 10;
`endif

endpackage

// File: rtl/kbd_scode_dec_if.sv
// Key-event stream from the decoder to the host-side consumer; valid/ready handshake.
interface kbd_scode_dec_if;
    logic [7:0] ev_code;
    logic       ev_brk;
    logic       ev_ext;
    logic [7:0] ev_ascii;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_code, ev_brk, ev_ext, ev_ascii, ev_valid, input ev_ready);
    modport slave  (input ev_code, ev_brk, ev_ext, ev_ascii, ev_valid, output ev_ready);
endinterface

// File: rtl/kbd_scode_dec_fifo.sv
// Generic synchronous FIFO, no fall-through: a push becomes visible at the head one edge later.
// Push on full is refused unless a pop happens in the same cycle; pop on empty is ignored.
module kbd_scode_dec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] dat_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dat_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign dat_o   = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= dat_i;
    end
endmodule

// File: rtl/kbd_scode_dec.sv
// PS/2 set-2 scan-code decoder: bytes -> key events buffered in a FIFO, 2-cycle strobe-to-valid latency.
// Events are dropped (sticky ovf) when the FIFO is full; ASCII output only with KBD_DEC_ASCII_EN.
module kbd_scode_dec
    import kbd_scode_dec_pkg::*;
#(
    parameter int          P_FIFO_DEPTH  = 8,
    parameter logic [31:0] P_PFX_TIMEOUT = 32'd1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       scode,
    input  logic             scode_en,
    input  logic [7:0]       rx_err,
    kbd_scode_dec_if.master  ev,
    output logic [3:0]       mods,
    output logic             bat_ok,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic [7:0]       err_cnt
);
    kbd_state_e  state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  err_q, err_d;
    logic [3:0]  mods_q, mods_d;
    kbd_ev_t     ev_q;
    logic        ev_push_q, bat_q, ovf_q;

    logic        emit_d, brk_d, ext_d, err_inc, bat_d;
    logic [7:0]  code_d, ascii_d;
    logic        is_pfx, is_fake;
    logic        fifo_full, fifo_empty, pop, drop;
    logic [EV_W-1:0] fifo_in, fifo_out;

    assign is_pfx  = (scode == SC_BRK) || (scode == SC_EXT) || (scode == SC_PAUSE);
    assign is_fake = (scode == SC_LSHIFT) || (scode == SC_RSHIFT);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = tmo_q;
        emit_d  = 1'b0;
        brk_d   = 1'b0;
        ext_d   = 1'b0;
        code_d  = scode;
        err_inc = 1'b0;
        bat_d   = 1'b0;
        if (scode_en) begin
            tmo_d = '0;
            if (rx_err[2:0] != 3'b000) begin
                state_d = S_IDLE;
                err_inc = 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        case (scode)
                            SC_BRK:   state_d = S_BRK;
                            SC_EXT:   state_d = S_EXT;
                            SC_PAUSE: begin
                                state_d = S_PAUSE;
                                skip_d  = PAUSE_SKIP;
                            end
                            SC_BAT:                     bat_d   = 1'b1;
                            8'h00, 8'hFF:               err_inc = 1'b1;
                            SC_ACK, SC_RESEND, SC_ECHO: ;
                            default:                    emit_d  = 1'b1;
                        endcase
                    end
                    S_BRK: begin
                        state_d = S_IDLE;
                        err_inc = is_pfx;
                        emit_d  = ~is_pfx;
                        brk_d   = 1'b1;
                    end
                    S_EXT: begin
                        if (scode == SC_BRK) begin
                            state_d = S_EXT_BRK;
                        end else begin
                            // E0 12 / E0 59 are synthetic shifts wrapped around extended keys
                            state_d = S_IDLE;
                            emit_d  = ~is_fake;
                            ext_d   = 1'b1;
                        end
                    end
                    S_EXT_BRK: begin
                        state_d = S_IDLE;
                        err_inc = is_pfx;
                        emit_d  = ~is_pfx & ~is_fake;
                        brk_d   = 1'b1;
                        ext_d   = 1'b1;
                    end
                    S_PAUSE: begin
                        if (skip_q == 3'd1) begin
                            state_d = S_IDLE;
                            emit_d  = 1'b1;
                            code_d  = SC_PAUSE;
                        end else begin
                            skip_d = skip_q - 3'd1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end else if (state_q != S_IDLE) begin
            if (tmo_q == P_PFX_TIMEOUT - 32'd1) begin
                state_d = S_IDLE;
                tmo_d   = '0;
                err_inc = 1'b1;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    always_comb begin
        mods_d = mods_q;
        if (emit_d) begin
            case (code_d)
                SC_LSHIFT: mods_d[0] = ~brk_d;
                SC_RSHIFT: mods_d[1] = ~brk_d;
                SC_CTRL:   mods_d[2] = ~brk_d;
                SC_ALT:    mods_d[3] = ~brk_d;
                default:   ;
            endcase
        end
    end

    assign err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

`ifdef KBD_DEC_ASCII_EN
    assign ascii_d = (brk_d | ext_d) ? 8'h00 : kbd_ascii(code_d, mods_q[0] | mods_q[1]);
`else
    assign ascii_d = 8'h00;
`endif

    assign pop  = ~fifo_empty & ev.ev_ready;
    assign drop = ev_push_q & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            skip_q    <= '0;
            tmo_q     <= '0;
            err_q     <= '0;
            mods_q    <= '0;
            ev_q      <= '0;
            ev_push_q <= 1'b0;
            bat_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            mods_q    <= mods_d;
            ev_push_q <= emit_d;
            bat_q     <= bat_d;
            if (emit_d) begin
                ev_q.code  <= code_d;
                ev_q.brk   <= brk_d;
                ev_q.ext   <= ext_d;
                ev_q.ascii <= ascii_d;
            end
            if (ovf_clr)   ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

`ifdef KBD_DEC_ASCII_EN
    assign fifo_in     = ev_q;
    assign ev.ev_ascii = fifo_out[7:0];
`else
    logic unused_ascii;
    assign unused_ascii = |ev_q.ascii;
    assign fifo_in      = {ev_q.code, ev_q.brk, ev_q.ext};
    assign ev.ev_ascii  = 8'h00;
`endif

    kbd_scode_dec_fifo #(
        .DEPTH (P_FIFO_DEPTH),
        .WIDTH (EV_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (ev_push_q),
        .dat_i   (fifo_in),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dat_o   (fifo_out)
    );

    assign ev.ev_code  = fifo_out[EV_W-1 -: 8];
    assign ev.ev_brk   = fifo_out[EV_W-9];
    assign ev.ev_ext   = fifo_out[EV_W-10];
    assign ev.ev_valid = ~fifo_empty;

    assign mods    = mods_q;
    assign bat_ok  = bat_q;
    assign ovf     = ovf_q;
    assign err_cnt = err_q;
endmodule

// File: tb/tb_kbd_scode_dec.sv
// Directed bench for kbd_scode_dec with an event scoreboard; honours KBD_DEC_ASCII_EN.
module tb_kbd_scode_dec;
    localparam logic [31:0] TMO = 32'd40;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic [7:0] ascii;
    } tev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scode = 8'h00;
    logic       scode_en = 1'b0;
    logic [7:0] rx_err = 8'h00;
    logic [3:0] mods;
    logic       bat_ok, ovf;
    logic       ovf_clr = 1'b0;
    logic [7:0] err_cnt;

    int   total = 0;
    int   bad = 0;
    int   exp_err = 0;
    tev_t exp_q[$];

    kbd_scode_dec_if ev_if();

    kbd_scode_dec #(.P_FIFO_DEPTH(8), .P_PFX_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .scode(scode), .scode_en(scode_en), .rx_err(rx_err),
        .ev(ev_if), .mods(mods), .bat_ok(bat_ok), .ovf(ovf), .ovf_clr(ovf_clr),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [7:0] a);
`ifdef KBD_DEC_ASCII_EN
        return a;
`else
        return 8'h00 & a;
`endif
    endfunction

    task automatic expect_ev(input logic [7:0] c, input logic b, input logic e, input logic [7:0] a);
        exp_q.push_back('{code: c, brk: b, ext: e, ascii: a});
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] e = 8'h00);
        @(posedge clk);
        #1 scode = b; scode_en = 1'b1; rx_err = e;
        @(posedge clk);
        #1 scode_en = 1'b0; rx_err = 8'h00;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ev_extra: observed code=%0h brk=%0b ext=%0b, required no event",
                         ev_if.ev_code, ev_if.ev_brk, ev_if.ev_ext);
            end else begin
                tev_t e;
                e = exp_q.pop_front();
                chk("ev", {14'd0, ev_if.ev_code, ev_if.ev_brk, ev_if.ev_ext, ev_if.ev_ascii},
                    {14'd0, e});
            end
        end
    end

    initial begin
        ev_if.ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("rst_mods", 32'(mods), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_bat", 32'(bat_ok), 32'd0);

        // strobe-to-valid latency with the consumer stalled
        send(8'h1C);
        chk("lat_n1", 32'(ev_if.ev_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_n2", 32'(ev_if.ev_valid), 32'd1);
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h61));
        ev_if.ev_ready = 1'b1;
        wait_drain("drain_lat");

        expect_ev(8'h12, 1'b0, 1'b0, 8'h00);
        send(8'h12);
        chk("lshift_set", 32'(mods), 32'h1);
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h41));
        send(8'h1C);
        expect_ev(8'h1C, 1'b1, 1'b0, 8'h00);
        send(8'hF0); send(8'h1C);
        expect_ev(8'h12, 1'b1, 1'b0, 8'h00);
        send(8'hF0); send(8'h12);
        chk("lshift_clr", 32'(mods), 32'h0);

        expect_ev(8'h75, 1'b1, 1'b1, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev(8'h7C, 1'b0, 1'b1, 8'h00);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        chk("fake_shift_mods", 32'(mods), 32'h0);
        expect_ev(8'h14, 1'b0, 1'b1, 8'h00);
        send(8'hE0); send(8'h14);
        chk("rctrl_set", 32'(mods), 32'h4);
        expect_ev(8'h14, 1'b1, 1'b1, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h14);
        chk("rctrl_clr", 32'(mods), 32'h0);

        expect_ev(8'hE1, 1'b0, 1'b0, 8'h00);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        wait_drain("drain_pause");
        chk("pause_err", 32'(err_cnt), 32'(exp_err));
        chk("pause_mods", 32'(mods), 32'h0);

        send(8'hAA);
        chk("bat_pulse", 32'(bat_ok), 32'd1);
        @(posedge clk);
        #1 chk("bat_end", 32'(bat_ok), 32'd0);
        send(8'hFA); send(8'h00);
        exp_err++;
        chk("err_zero_byte", 32'(err_cnt), 32'(exp_err));

        // fill the FIFO past its depth while stalled
        ev_if.ev_ready = 1'b0;
        begin
            logic [7:0] codes [9];
            logic [7:0] chars [9];
            codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
            chars = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69, 8'h6F};
            for (int i = 0; i < 9; i++) begin
                if (i < 8) expect_ev(codes[i], 1'b0, 1'b0, asc(chars[i]));
                send(codes[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1 chk("ovf_set", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1 ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        ev_if.ev_ready = 1'b1;
        wait_drain("drain_ovf");

        send(8'hF0);
        repeat (TMO - 1) @(posedge clk);
        #1 chk("tmo_before", 32'(err_cnt), 32'(exp_err));
        @(posedge clk);
        exp_err++;
        #1 chk("tmo_fire", 32'(err_cnt), 32'(exp_err));
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h61));
        send(8'h1C);

        send(8'h1C, 8'h01);
        exp_err++;
        chk("rx_err_parity", 32'(err_cnt), 32'(exp_err));
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h61));
        send(8'h1C, 8'h08);
        chk("rx_err_hi_bits", 32'(err_cnt), 32'(exp_err));
        send(8'hE0); send(8'h1C, 8'h04);
        exp_err++;
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h61));
        send(8'h1C);
        chk("rx_err_mid_seq", 32'(err_cnt), 32'(exp_err));

        send(8'hF0); send(8'hE0);
        exp_err++;
        chk("proto_err", 32'(err_cnt), 32'(exp_err));
        expect_ev(8'h1C, 1'b0, 1'b0, asc(8'h61));
        send(8'h1C);
        wait_drain("drain_err");

        while (exp_err < 255) begin
            send(8'hFF);
            exp_err++;
        end
        chk("err_at_ff", 32'(err_cnt), 32'hFF);
        send(8'h00);
        chk("err_saturate", 32'(err_cnt), 32'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
